lvds_panel_pwr_seq: RTL and testbench

//  Power/enable sequencer for the LVDS panel path in the 65 MHz pixel domain.
//  - Drives panel VDD, the LVDS serializer/data-generator enable and the backlight (enable + PWM)
//    in the order and with the spacing the panel datasheet requires.
//  - Sits between the MMCM-lock reset and the data_generator / lvds_output_driver pair.
//  - Replaces the hard-tied backlight output in LVDS_top.

---
 rtl/lvds_panel_pwr_seq.sv | 98 +++++++++
 tb/tb_lvds_panel_pwr_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/lvds_panel_pwr_seq.sv
// lvds_panel_pwr_seq: panel VDD / LVDS enable / backlight power sequencer with backlight PWM (ports: i_clk_65mhz, i_rst, i_pwr_req, i_bl_duty -> o_panel_vdd, o_lvds_en, o_bl_en, o_bl_pwm, o_panel_on, o_state)
module lvds_panel_pwr_seq #(
  parameter int CYC_PER_MS = 65000,
  parameter int T1_MS      = 20,
  parameter int T2_MS      = 200,
  parameter int T3_MS      = 200,
  parameter int T4_MS      = 20,
  parameter int T5_MS      = 500,
  parameter int PWM_DIV    = 16
) (
  input  logic       i_clk_65mhz,
  input  logic       i_rst,
  input  logic       i_pwr_req,
  input  logic [7:0] i_bl_duty,
  output logic       o_panel_vdd,
  output logic       o_lvds_en,
  output logic       o_bl_en,
  output logic       o_bl_pwm,
  output logic       o_panel_on,
  output logic [2:0] o_state
);
  typedef enum logic [2:0] {OFF, UP1, UP2, ACTIVE, DN1, DN2, COOL} state_t;
  localparam int TA   = T1_MS > T2_MS ? T1_MS : T2_MS;
  localparam int TB   = T3_MS > T4_MS ? T3_MS : T4_MS;
  localparam int TC   = TA > TB ? TA : TB;
  localparam int TMAX = TC > T5_MS ? TC : T5_MS;
  localparam int PW   = $clog2(CYC_PER_MS + 1);
  localparam int MW   = $clog2(TMAX + 1);
  localparam int DW   = $clog2(PWM_DIV + 1);
  state_t state, state_n;
  logic [PW-1:0] pre;
  logic [MW-1:0] ms, dly;
  logic [DW-1:0] div, div_n;
  logic [7:0] pwm_cnt, pwm_cnt_n, duty_q, duty_n;
  logic expired, vdd_n, lvds_n, bl_n, pwm_n, rise, step;
  assign o_state = state;
  always_comb begin
    dly = state == UP1 ? MW'(T1_MS) : state == UP2 ? MW'(T2_MS) : state == DN1 ? MW'(T3_MS) :
          state == DN2 ? MW'(T4_MS) : state == COOL ? MW'(T5_MS) : MW'(1);
    expired = pre == PW'(CYC_PER_MS - 1) && ms == dly - 1'b1;
    state_n = state;
    case (state)
      OFF:     state_n = i_pwr_req ? UP1 : OFF;
      UP1:     state_n = expired ? UP2 : !i_pwr_req ? DN2 : UP1;
      UP2:     state_n = expired ? ACTIVE : !i_pwr_req ? DN1 : UP2;
      ACTIVE:  state_n = i_pwr_req ? ACTIVE : DN1;
      DN1:     state_n = expired ? DN2 : DN1;
      DN2:     state_n = expired ? COOL : DN2;
      COOL:    state_n = expired ? OFF : COOL;
      default: state_n = OFF;
    endcase
    vdd_n  = state_n inside {UP1, UP2, ACTIVE, DN1, DN2};
    lvds_n = state_n inside {UP2, ACTIVE, DN1};
    bl_n   = state_n == ACTIVE;
    // PWM next values are computed here so o_bl_pwm can be registered yet match pwm_cnt < duty_q exactly
    rise      = bl_n & ~o_bl_en;
    step      = o_bl_en & (div == DW'(PWM_DIV - 1));
    div_n     = rise ? '0 : !o_bl_en ? div : step ? '0 : div + 1'b1;
    pwm_cnt_n = rise ? 8'd0 : step ? pwm_cnt + 8'd1 : pwm_cnt;
    duty_n    = (rise || (step && pwm_cnt == 8'hff)) ? i_bl_duty : duty_q;
    pwm_n     = bl_n & (pwm_cnt_n < duty_n);
  end
  always_ff @(posedge i_clk_65mhz) begin
    if (i_rst) begin
      state       <= OFF;
      pre         <= '0;
      ms          <= '0;
      div         <= '0;
      pwm_cnt     <= 8'd0;
      duty_q      <= 8'd0;
      o_panel_vdd <= 1'b0;
      o_lvds_en   <= 1'b0;
      o_bl_en     <= 1'b0;
      o_bl_pwm    <= 1'b0;
      o_panel_on  <= 1'b0;
    end else begin
      state       <= state_n;
      div         <= div_n;
      pwm_cnt     <= pwm_cnt_n;
      duty_q      <= duty_n;
      o_panel_vdd <= vdd_n;
      o_lvds_en   <= lvds_n;
      o_bl_en     <= bl_n;
      o_bl_pwm    <= pwm_n;
      o_panel_on  <= bl_n;
      // Timer restarts on every state entry and idles in the untimed states
      if (state_n != state || state == OFF || state == ACTIVE) begin
        pre <= '0;
        ms  <= '0;
      end else if (pre == PW'(CYC_PER_MS - 1)) begin
        pre <= '0;
        ms  <= ms + 1'b1;
      end else begin
        pre <= pre + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_lvds_panel_pwr_seq.sv
// tb_lvds_panel_pwr_seq: scenario tasks plus a cycle-level reference model of the power sequencer
module tb_lvds_panel_pwr_seq;
  localparam int CYC = 4;
  logic clk = 0, rst = 1, req = 0;
  logic [7:0] duty = 0;
  logic vdd, lvds, bl, pwm, pon;
  logic [2:0] st;
  int checks = 0, errors = 0;
  bit mon_en = 0;
  always #5 clk = ~clk;
  lvds_panel_pwr_seq #(.CYC_PER_MS(CYC), .T1_MS(2), .T2_MS(3), .T3_MS(3), .T4_MS(2), .T5_MS(5), .PWM_DIV(1)) dut (
    .i_clk_65mhz(clk), .i_rst(rst), .i_pwr_req(req), .i_bl_duty(duty),
    .o_panel_vdd(vdd), .o_lvds_en(lvds), .o_bl_en(bl), .o_bl_pwm(pwm), .o_panel_on(pon), .o_state(st));
  int dur[7]  = '{0, 2, 3, 0, 3, 2, 5};
  int succ[7] = '{0, 2, 3, 3, 5, 6, 0};
  int abrt[7] = '{-1, 5, 4, -1, -1, -1, -1};
  int m_st = 0, m_rem = 0, m_k = 0, m_duty = 0;
  bit m_bl = 0;
  always @(posedge clk) begin
    int nx;
    if (rst) begin
      m_st = 0; m_rem = 0; m_bl = 0; m_k = 0; m_duty = 0;
    end else begin
      nx = m_st;
      if (dur[m_st] > 0) begin
        m_rem--;
        if (m_rem == 0) nx = succ[m_st];
        else if (!req && abrt[m_st] >= 0) nx = abrt[m_st];
      end else if (m_st == 0 && req) nx = 1;
      else if (m_st == 3 && !req) nx = 4;
      if (nx != m_st) m_rem = dur[nx] * CYC;
      m_st = nx;
      if (m_st == 3 && !m_bl) begin
        m_k = 0; m_duty = duty;
      end else if (m_bl) begin
        m_k = (m_k + 1) % 256;
        if (m_k == 0) m_duty = duty;
      end
      m_bl = (m_st == 3);
    end
  end
  always @(negedge clk) if (mon_en) begin
    logic [7:0] e, g;
    e = {m_st inside {1, 2, 3, 4, 5}, m_st inside {2, 3, 4}, m_st == 3, m_bl && m_k < m_duty, m_st == 3, 3'(m_st)};
    g = {vdd, lvds, bl, pwm, pon, st};
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL model t=%0t got vdd/lvds/bl/pwm/on/state=%b required %b", $time, g, e);
    end
  end
  task automatic run_until(input int s, input int budget);
    int n = 0;
    while (st !== 3'(s) && n < budget) begin @(negedge clk); n++; end
    checks++;
    if (st !== 3'(s)) begin errors++; $display("FAIL wait_state got %0d required %0d", st, s); end
  endtask
  task automatic test_reset;
    rst = 1; req = 0;
    repeat (2) @(negedge clk);
    mon_en = 1;
    checks++; if ({vdd, lvds, bl, pwm, pon} !== 5'b0) begin errors++; $display("FAIL reset_outs got %b required 00000", {vdd, lvds, bl, pwm, pon}); end
    checks++; if (st !== 3'd0) begin errors++; $display("FAIL reset_state got %0d required 0", st); end
    rst = 0;
    @(negedge clk);
  endtask
  task automatic test_power_up;
    int tv = -1, tl = -1, tb = -1;
    logic [2:0] sv = 0, sl = 0, sb = 0;
    logic po = 0;
    req = 1;
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      if (vdd === 1'b1 && tv < 0) begin tv = t; sv = st; end
      if (lvds === 1'b1 && tl < 0) begin tl = t; sl = st; end
      if (bl === 1'b1 && tb < 0) begin tb = t; sb = st; po = pon; end
    end
    checks++; if (tv != 1) begin errors++; $display("FAIL up_vdd got %0d required 1", tv); end
    checks++; if (tl - tv != 8) begin errors++; $display("FAIL up_lvds got %0d required 8", tl - tv); end
    checks++; if (tb - tl != 12) begin errors++; $display("FAIL up_bl got %0d required 12", tb - tl); end
    checks++; if ({sv, sl, sb} !== {3'd1, 3'd2, 3'd3}) begin errors++; $display("FAIL up_states got %0d,%0d,%0d required 1,2,3", sv, sl, sb); end
    checks++; if (po !== 1'b1) begin errors++; $display("FAIL up_panel_on got %b required 1", po); end
  endtask
  task automatic test_power_down;
    int tb = -1, tl = -1, tv = -1, to = -1;
    logic [2:0] sv = 0;
    req = 0;
    for (int t = 1; t <= 60; t++) begin
      @(negedge clk);
      if (bl === 1'b0 && tb < 0) tb = t;
      if (lvds === 1'b0 && tl < 0) tl = t;
      if (vdd === 1'b0 && tv < 0) begin tv = t; sv = st; end
      if (st === 3'd0 && to < 0) to = t;
    end
    checks++; if (tb != 1) begin errors++; $display("FAIL dn_bl got %0d required 1", tb); end
    checks++; if (tl - tb != 12) begin errors++; $display("FAIL dn_lvds got %0d required 12", tl - tb); end
    checks++; if (tv - tl != 8) begin errors++; $display("FAIL dn_vdd got %0d required 8", tv - tl); end
    checks++; if (to - tv != 20) begin errors++; $display("FAIL dn_off got %0d required 20", to - tv); end
    checks++; if (sv !== 3'd6) begin errors++; $display("FAIL dn_cool got %0d required 6", sv); end
  endtask
  task automatic test_abort_up1;
    int tv = -1, to = -1;
    logic [2:0] s5 = 0;
    bit l = 0;
    req = 1;
    for (int t = 1; t <= 50; t++) begin
      @(negedge clk);
      if (t == 5) s5 = st;
      if (lvds === 1'b1) l = 1;
      if (t > 1 && vdd === 1'b0 && tv < 0) tv = t;
      if (t > 1 && st === 3'd0 && to < 0) to = t;
      if (t == 4) req = 0;
    end
    checks++; if (s5 !== 3'd5) begin errors++; $display("FAIL ab1_state got %0d required 5", s5); end
    checks++; if (l) begin errors++; $display("FAIL ab1_lvds got 1 required 0"); end
    checks++; if (tv != 13) begin errors++; $display("FAIL ab1_vdd got %0d required 13", tv); end
    checks++; if (to != 33) begin errors++; $display("FAIL ab1_off got %0d required 33", to); end
  endtask
  task automatic test_abort_up2;
    int to = -1;
    logic [2:0] s9 = 0, s12 = 0;
    bit b = 0;
    req = 1;
    for (int t = 1; t <= 60; t++) begin
      @(negedge clk);
      if (t == 9) s9 = st;
      if (t == 12) s12 = st;
      if (bl === 1'b1) b = 1;
      if (t > 1 && st === 3'd0 && to < 0) to = t;
      if (t == 11) req = 0;
    end
    checks++; if ({s9, s12} !== {3'd2, 3'd4}) begin errors++; $display("FAIL ab2_states got %0d,%0d required 2,4", s9, s12); end
    checks++; if (b) begin errors++; $display("FAIL ab2_bl got 1 required 0"); end
    checks++; if (to != 52) begin errors++; $display("FAIL ab2_off got %0d required 52", to); end
  endtask
  task automatic test_expiry_vs_abort;
    logic [2:0] s21 = 0, s22 = 0;
    req = 1;
    for (int t = 1; t <= 30; t++) begin
      @(negedge clk);
      if (t == 21) s21 = st;
      if (t == 22) s22 = st;
      if (t == 20) req = 0;
    end
    checks++; if ({s21, s22} !== {3'd3, 3'd4}) begin errors++; $display("FAIL exp_win got %0d,%0d required 3,4", s21, s22); end
    run_until(0, 60);
  endtask
  task automatic test_cool_rereq;
    int tv = -1, tl = -1;
    logic [2:0] s20 = 7, sv = 0;
    req = 1;
    run_until(3, 40);
    req = 0;
    run_until(6, 40);
    req = 1;
    for (int t = 1; t <= 30; t++) begin
      @(negedge clk);
      if (t == 20) s20 = st;
      if (vdd === 1'b1 && tv < 0) begin tv = t; sv = st; end
      if (lvds === 1'b1 && tl < 0) tl = t;
    end
    checks++; if (tv != 21) begin errors++; $display("FAIL cool_vdd got %0d required 21", tv); end
    checks++; if (s20 !== 3'd0 || sv !== 3'd1) begin errors++; $display("FAIL cool_states got %0d,%0d required 0,1", s20, sv); end
    checks++; if (tl != 29) begin errors++; $display("FAIL cool_lvds got %0d required 29", tl); end
  endtask
  task automatic test_pwm;
    int c[5] = '{0, 0, 0, 0, 0};
    int n = 0;
    bit drop = 0;
    duty = 8'd64;
    while (bl !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++; if (bl !== 1'b1) begin errors++; $display("FAIL pwm_bl got %b required 1", bl); end
    for (int t = 0; t < 1280; t++) begin
      if (t > 0) @(negedge clk);
      if (bl !== 1'b1) drop = 1;
      if (pwm === 1'b1) begin
        if (t < 256) c[0]++;
        else if (t >= 356 && t < 512) c[1]++;
        else if (t >= 512 && t < 768) c[2]++;
        else if (t >= 768 && t < 1024) c[3]++;
        else if (t >= 1024) c[4]++;
      end
      if (t == 355) duty = 8'd192;
      if (t == 767) duty = 8'd0;
      if (t == 1023) duty = 8'd255;
    end
    checks++; if (c[0] != 64) begin errors++; $display("FAIL pwm_64 got %0d required 64", c[0]); end
    checks++; if (c[1] != 0) begin errors++; $display("FAIL pwm_midchange got %0d required 0", c[1]); end
    checks++; if (c[2] != 192) begin errors++; $display("FAIL pwm_192 got %0d required 192", c[2]); end
    checks++; if (c[3] != 0) begin errors++; $display("FAIL pwm_0 got %0d required 0", c[3]); end
    checks++; if (c[4] != 255) begin errors++; $display("FAIL pwm_255 got %0d required 255", c[4]); end
    checks++; if (drop) begin errors++; $display("FAIL pwm_bl_hold got 0 required 1"); end
  endtask
  task automatic test_reset_active;
    int tv = -1, tl = -1;
    rst = 1;
    @(negedge clk);
    checks++; if ({vdd, lvds, bl, pwm, pon, st} !== 8'b0) begin errors++; $display("FAIL rst_active got %b required 0", {vdd, lvds, bl, pwm, pon, st}); end
    rst = 0;
    for (int t = 1; t <= 20; t++) begin
      @(negedge clk);
      if (vdd === 1'b1 && tv < 0) tv = t;
      if (lvds === 1'b1 && tl < 0) tl = t;
    end
    checks++; if (tv != 1 || tl != 9) begin errors++; $display("FAIL rst_reup got %0d,%0d required 1,9", tv, tl); end
  endtask
  task automatic test_random;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 799) == 0);
      if ($urandom_range(0, 39) == 0) req = ~req;
      if ($urandom_range(0, 49) == 0) duty = 8'($urandom);
    end
    rst = 0;
  endtask
  initial begin
    test_reset;
    test_power_up;
    test_power_down;
    test_abort_up1;
    test_abort_up2;
    test_expiry_vs_abort;
    test_cool_rereq;
    test_pwm;
    test_reset_active;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end
endmodule
